lpc_io_target: RTL and testbench

- Parametrised LPC I/O-cycle target. Decodes host IORD/IOWR cycles that hit a configurable address window and forwards each hit as a single byte access on a req/ack register bus.
- Generates SYNC with long-wait and error reporting, so a slow back-end (UART core, GPIO, config block) can stretch the cycle.
- Sits between the board LPC pins and the peripheral register file, replacing the fixed-address, fixed-latency decoder.

---
 rtl/lpc_io_target.sv | 200 ++++++++++++++++++++
 tb/tb_lpc_io_target.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target: decodes IORD/IOWR hits in an address window and forwards each
// as one byte access on a req/ack register bus, stretching the cycle with long-wait SYNC.
module lpc_io_target #(
    parameter logic [15:0] BASE_ADDR = 16'h03F8,
    parameter int unsigned ADDR_BITS = 3,
    parameter int unsigned MAX_WAIT  = 15
) (
    input  logic                 lpc_clk,
    input  logic                 lpc_rst,
    input  logic                 lpc_frame,
    input  logic [3:0]           lpc_ad_in,
    output logic [3:0]           lpc_ad_out,
    output logic                 lpc_ad_oe,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [7:0]           reg_wdata,
    output logic                 reg_wr,
    output logic                 reg_rd,
    input  logic [7:0]           reg_rdata,
    input  logic                 reg_ack,
    output logic                 sync_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
    localparam logic [3:0] SYNC_READY = 4'h0;
    localparam logic [3:0] SYNC_LWAIT = 4'h6;
    localparam logic [3:0] SYNC_ERROR = 4'hA;

    typedef enum logic [3:0] {
        IDLE, CTDIR, ADDR3, ADDR2, ADDR1, ADDR0, WDATA0, WDATA1,
        HTAR0, HTAR1, SYNC, RDATA0, RDATA1, TTAR0, TTAR1
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   wait_cnt, cnt_nx;
    logic               ack_done, ack_nx;
    logic               is_wr, is_wr_nx;
    logic [11:0]        addr_sh, shift_nx;
    logic [3:0]         wlo, wlo_nx;
    logic [7:0]         rdata_q, rdata_nx;
    logic [3:0]         ad_nx;
    logic               oe_nx, wr_nx, rd_nx, err_nx;
    logic [ADDR_BITS-1:0] addr_nx;
    logic [7:0]         wdata_nx;
    logic [15:0]        full_addr;
    logic [3:0]         sync_code;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_nx  = state;
        cnt_nx    = wait_cnt;
        ack_nx    = ack_done;
        is_wr_nx  = is_wr;
        shift_nx  = addr_sh;
        wlo_nx    = wlo;
        rdata_nx  = rdata_q;
        ad_nx     = 4'h0;
        oe_nx     = 1'b0;
        wr_nx     = reg_wr;
        rd_nx     = reg_rd;
        err_nx    = 1'b0;
        addr_nx   = reg_addr;
        wdata_nx  = reg_wdata;
        full_addr = {addr_sh, lpc_ad_in};
        sync_code = ack_done ? SYNC_READY :
                    ((wait_cnt < WAIT_LIMIT) ? SYNC_LWAIT : SYNC_ERROR);

        // A pending request completes on the first sampled ack; idle acks are ignored.
        if ((reg_wr || reg_rd) && reg_ack) begin
            wr_nx  = 1'b0;
            rd_nx  = 1'b0;
            ack_nx = 1'b1;
            if (reg_rd) rdata_nx = reg_rdata;
        end

        if (!lpc_frame) begin
            state_nx = (lpc_ad_in == 4'h0) ? CTDIR : IDLE;
            wr_nx    = 1'b0;
            rd_nx    = 1'b0;
            cnt_nx   = '0;
            ack_nx   = 1'b0;
        end else begin
            case (state)
                IDLE: state_nx = IDLE;
                CTDIR: begin
                    if (lpc_ad_in[3:1] == 3'b000) begin
                        is_wr_nx = 1'b0;
                        state_nx = ADDR3;
                    end else if (lpc_ad_in[3:1] == 3'b001) begin
                        is_wr_nx = 1'b1;
                        state_nx = ADDR3;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                ADDR3, ADDR2, ADDR1: begin
                    shift_nx = {addr_sh[7:0], lpc_ad_in};
                    state_nx = (state == ADDR3) ? ADDR2 : ((state == ADDR2) ? ADDR1 : ADDR0);
                end
                ADDR0: begin
                    if (full_addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]) begin
                        addr_nx = full_addr[ADDR_BITS-1:0];
                        if (is_wr) begin
                            state_nx = WDATA0;
                        end else begin
                            state_nx = HTAR0;
                            rd_nx    = 1'b1;
                            cnt_nx   = '0;
                            ack_nx   = 1'b0;
                        end
                    end else begin
                        state_nx = IDLE;
                    end
                end
                WDATA0: begin
                    wlo_nx   = lpc_ad_in;
                    state_nx = WDATA1;
                end
                WDATA1: begin
                    wdata_nx = {lpc_ad_in, wlo};
                    wr_nx    = 1'b1;
                    cnt_nx   = '0;
                    ack_nx   = 1'b0;
                    state_nx = HTAR0;
                end
                HTAR0: state_nx = HTAR1;
                // Each SYNC nibble is decided one edge ahead, from HTAR1 or a previous long wait.
                HTAR1, SYNC: begin
                    oe_nx = 1'b1;
                    if (state == HTAR1 || lpc_ad_out == SYNC_LWAIT) begin
                        state_nx = SYNC;
                        ad_nx    = sync_code;
                        if (sync_code == SYNC_LWAIT) begin
                            cnt_nx = wait_cnt + CNT_W'(1);
                        end else if (sync_code == SYNC_ERROR) begin
                            wr_nx  = 1'b0;
                            rd_nx  = 1'b0;
                            err_nx = 1'b1;
                        end
                    end else if (lpc_ad_out == SYNC_READY && !is_wr) begin
                        state_nx = RDATA0;
                        ad_nx    = rdata_q[3:0];
                    end else begin
                        state_nx = TTAR0;
                        ad_nx    = 4'hF;
                    end
                end
                RDATA0: begin
                    oe_nx    = 1'b1;
                    ad_nx    = rdata_q[7:4];
                    state_nx = RDATA1;
                end
                RDATA1: begin
                    oe_nx    = 1'b1;
                    ad_nx    = 4'hF;
                    state_nx = TTAR0;
                end
                TTAR0: state_nx = TTAR1;
                TTAR1: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge lpc_clk or negedge lpc_rst) begin
        if (!lpc_rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            ack_done   <= 1'b0;
            is_wr      <= 1'b0;
            addr_sh    <= '0;
            wlo        <= '0;
            rdata_q    <= '0;
            lpc_ad_out <= 4'h0;
            lpc_ad_oe  <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_wr     <= 1'b0;
            reg_rd     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            wait_cnt   <= cnt_nx;
            ack_done   <= ack_nx;
            is_wr      <= is_wr_nx;
            addr_sh    <= shift_nx;
            wlo        <= wlo_nx;
            rdata_q    <= rdata_nx;
            lpc_ad_out <= ad_nx;
            lpc_ad_oe  <= oe_nx;
            reg_addr   <= addr_nx;
            reg_wdata  <= wdata_nx;
            reg_wr     <= wr_nx;
            reg_rd     <= rd_nx;
            sync_err   <= err_nx;
        end
    end

endmodule

// File: tb/tb_lpc_io_target.sv
// Bench for lpc_io_target: drives LPC I/O cycles, models the register back-end and
// scoreboards expected register requests and driven LAD nibbles.
module tb_lpc_io_target;

    localparam int unsigned ADDR_BITS = 3;
    localparam int unsigned MAX_WAIT  = 15;
    localparam logic [15:0] BASE      = 16'h03F8;
    localparam int          NEVER     = 1000;

    logic                 lpc_clk   = 1'b0;
    logic                 lpc_rst   = 1'b0;
    logic                 lpc_frame = 1'b1;
    logic [3:0]           lpc_ad_in = 4'hF;
    logic [3:0]           lpc_ad_out;
    logic                 lpc_ad_oe;
    logic [ADDR_BITS-1:0] reg_addr;
    logic [7:0]           reg_wdata;
    logic                 reg_wr;
    logic                 reg_rd;
    logic [7:0]           reg_rdata = 8'h00;
    logic                 reg_ack   = 1'b0;
    logic                 sync_err;

    typedef struct {
        bit                   wr;
        logic [ADDR_BITS-1:0] addr;
        logic [7:0]           data;
    } req_t;

    req_t       exp_req[$];
    logic [3:0] exp_lad[$];
    req_t       e_req;
    logic [3:0] e_lad;
    int  n_checks  = 0;
    int  n_pass    = 0;
    int  err_count = 0;
    int  ack_dly   = 0;
    int  req_age   = 0;
    bit  ack_hold  = 1'b0;
    logic prev_wr  = 1'b0;
    logic prev_rd  = 1'b0;

    lpc_io_target #(
        .BASE_ADDR(BASE),
        .ADDR_BITS(ADDR_BITS),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .lpc_clk   (lpc_clk),
        .lpc_rst   (lpc_rst),
        .lpc_frame (lpc_frame),
        .lpc_ad_in (lpc_ad_in),
        .lpc_ad_out(lpc_ad_out),
        .lpc_ad_oe (lpc_ad_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .sync_err  (sync_err)
    );

    always #5 lpc_clk = ~lpc_clk;

    // Back-end model: ack after ack_dly request cycles, or held high throughout.
    always @(negedge lpc_clk) begin
        if (reg_wr || reg_rd) begin
            reg_ack = ack_hold || (req_age == ack_dly);
            req_age = req_age + 1;
        end else begin
            reg_ack = ack_hold;
            req_age = 0;
        end
    end

    // Scoreboard: every driven nibble and every new request is matched against the queues.
    always @(negedge lpc_clk) begin
        if (lpc_ad_oe === 1'b1) begin
            n_checks++;
            if (exp_lad.size() == 0) begin
                $display("FAIL lad_extra: drove %h, expected no drive", lpc_ad_out);
            end else begin
                e_lad = exp_lad.pop_front();
                if (lpc_ad_out !== e_lad)
                    $display("FAIL lad: got %h expected %h", lpc_ad_out, e_lad);
                else
                    n_pass++;
            end
        end
        if ((reg_wr === 1'b1 && !prev_wr) || (reg_rd === 1'b1 && !prev_rd)) begin
            n_checks++;
            if (exp_req.size() == 0) begin
                $display("FAIL req_extra: wr=%b rd=%b addr=%0d, expected no request",
                         reg_wr, reg_rd, reg_addr);
            end else begin
                e_req = exp_req.pop_front();
                if (reg_wr !== e_req.wr || reg_addr !== e_req.addr ||
                    (e_req.wr && reg_wdata !== e_req.data))
                    $display("FAIL req: got wr=%b addr=%0d data=%h expected wr=%b addr=%0d data=%h",
                             reg_wr, reg_addr, reg_wdata, e_req.wr, e_req.addr, e_req.data);
                else
                    n_pass++;
            end
        end
        if (sync_err === 1'b1) err_count++;
        prev_wr = reg_wr;
        prev_rd = reg_rd;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench still running at %0t, expected completion", $time);
        $fatal(1);
    end

    task automatic drive_header(input bit wr, input logic [15:0] addr, input logic [7:0] data);
        @(negedge lpc_clk); lpc_frame = 1'b0; lpc_ad_in = 4'h0;
        @(negedge lpc_clk); lpc_frame = 1'b1; lpc_ad_in = wr ? 4'h2 : 4'h0;
        for (int i = 3; i >= 0; i--) begin
            @(negedge lpc_clk); lpc_ad_in = addr[i*4 +: 4];
        end
        if (wr) begin
            @(negedge lpc_clk); lpc_ad_in = data[3:0];
            @(negedge lpc_clk); lpc_ad_in = data[7:4];
        end
    endtask

    // Full host cycle; j counts observation cycles from HTAR0.
    task automatic lpc_cycle(input string name, input bit wr, input logic [15:0] addr,
                             input logic [7:0] data, input logic [7:0] rdata, input int dly);
        bit   hit, ok, req_exp;
        int   waits, n, ttar1, err0;
        req_t r;
        hit   = (addr[15:ADDR_BITS] == BASE[15:ADDR_BITS]);
        ok    = (dly <= int'(MAX_WAIT));
        waits = ok ? dly : int'(MAX_WAIT);
        ack_dly   = dly;
        reg_rdata = rdata;
        ttar1 = -1;
        n     = 6;
        if (hit) begin
            r.wr = wr; r.addr = addr[ADDR_BITS-1:0]; r.data = data;
            exp_req.push_back(r);
            for (int i = 0; i < waits; i++) exp_lad.push_back(4'h6);
            exp_lad.push_back(ok ? 4'h0 : 4'hA);
            if (ok && !wr) begin
                exp_lad.push_back(rdata[3:0]);
                exp_lad.push_back(rdata[7:4]);
            end
            exp_lad.push_back(4'hF);
            ttar1 = 3 + waits + ((ok && !wr) ? 2 : 0) + 1;
            n     = ttar1 + 2;
        end
        err0 = err_count;
        drive_header(wr, addr, data);
        for (int j = 0; j < n; j++) begin
            @(negedge lpc_clk);
            lpc_frame = 1'b1;
            lpc_ad_in = 4'hF;
            if (hit) begin
                req_exp = ok ? (j <= dly) : (j <= int'(MAX_WAIT) + 1);
                n_checks++;
                if ({reg_wr, reg_rd} !== {wr && req_exp, !wr && req_exp})
                    $display("FAIL %s req_level j=%0d: got wr=%b rd=%b expected wr=%b rd=%b",
                             name, j, reg_wr, reg_rd, wr && req_exp, !wr && req_exp);
                else
                    n_pass++;
                if (j < 2 || j == ttar1) begin
                    n_checks++;
                    if (lpc_ad_oe !== 1'b0)
                        $display("FAIL %s oe_turnaround j=%0d: got %b expected 0", name, j, lpc_ad_oe);
                    else
                        n_pass++;
                end
                if (!ok && j == 2 + waits) begin
                    n_checks++;
                    if (sync_err !== 1'b1)
                        $display("FAIL %s sync_err: got %b expected 1", name, sync_err);
                    else
                        n_pass++;
                end
            end else begin
                n_checks++;
                if ({lpc_ad_oe, reg_wr, reg_rd} !== 3'b000)
                    $display("FAIL %s miss_quiet j=%0d: got oe/wr/rd=%b expected 000",
                             name, j, {lpc_ad_oe, reg_wr, reg_rd});
                else
                    n_pass++;
            end
        end
        n_checks++;
        if (exp_lad.size() != 0 || exp_req.size() != 0)
            $display("FAIL %s pending: got lad=%0d req=%0d left expected 0/0",
                     name, exp_lad.size(), exp_req.size());
        else
            n_pass++;
        n_checks++;
        if (err_count - err0 != ((hit && !ok) ? 1 : 0))
            $display("FAIL %s err_pulses: got %0d expected %0d", name, err_count - err0,
                     (hit && !ok) ? 1 : 0);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        lpc_rst = 1'b0;
        repeat (3) @(negedge lpc_clk);
        n_checks++;
        if ({lpc_ad_oe, lpc_ad_out} !== 5'b0)
            $display("FAIL reset_lad: got oe=%b ad=%h expected 0/0", lpc_ad_oe, lpc_ad_out);
        else
            n_pass++;
        n_checks++;
        if ({reg_wr, reg_rd, sync_err} !== 3'b000)
            $display("FAIL reset_ctrl: got wr/rd/err=%b expected 000", {reg_wr, reg_rd, sync_err});
        else
            n_pass++;
        n_checks++;
        if ({reg_addr, reg_wdata} !== 11'b0)
            $display("FAIL reset_bus: got addr=%0d wdata=%h expected 0/00", reg_addr, reg_wdata);
        else
            n_pass++;
        lpc_rst = 1'b1;
        repeat (2) @(negedge lpc_clk);
    endtask

    task automatic test_write_zero_wait();
        ack_hold = 1'b1;
        lpc_cycle("wr_3f8", 1'b1, 16'h03F8, 8'h5A, 8'h00, 0);
        ack_hold = 1'b0;
    endtask

    task automatic test_read_wait();
        lpc_cycle("rd_3fd", 1'b0, 16'h03FD, 8'h00, 8'h60, 3);
        lpc_cycle("rd_max_wait", 1'b0, 16'h03FE, 8'h00, 8'h9B, int'(MAX_WAIT));
        lpc_cycle("rd_zero", 1'b0, 16'h03FF, 8'h00, 8'h17, 0);
    endtask

    task automatic test_miss();
        lpc_cycle("wr_miss", 1'b1, 16'h02F8, 8'h11, 8'h00, 0);
        lpc_cycle("rd_miss", 1'b0, 16'h0400, 8'h00, 8'h22, 0);
    endtask

    task automatic test_timeout();
        lpc_cycle("rd_timeout", 1'b0, 16'h03F8, 8'h00, 8'hC3, NEVER);
        lpc_cycle("wr_after_err", 1'b1, 16'h03FC, 8'h81, 8'h00, 2);
    endtask

    task automatic test_abort();
        @(negedge lpc_clk); lpc_frame = 1'b0; lpc_ad_in = 4'h0;
        @(negedge lpc_clk); lpc_frame = 1'b1; lpc_ad_in = 4'h2;
        @(negedge lpc_clk); lpc_ad_in = 4'h0;
        @(negedge lpc_clk); lpc_ad_in = 4'h3;
        @(negedge lpc_clk); lpc_frame = 1'b0; lpc_ad_in = 4'hF;
        lpc_cycle("wr_after_abort", 1'b1, 16'h03F9, 8'hA5, 8'h00, 0);
    endtask

    task automatic test_async_reset();
        req_t r;
        r.wr = 1'b0; r.addr = 3'd2; r.data = 8'h00;
        exp_req.push_back(r);
        repeat (3) exp_lad.push_back(4'h6);
        ack_dly = NEVER;
        drive_header(1'b0, 16'h03FA, 8'h00);
        for (int j = 0; j < 5; j++) begin
            @(negedge lpc_clk);
            lpc_frame = 1'b1;
            lpc_ad_in = 4'hF;
        end
        #1 lpc_rst = 1'b0;
        #1;
        n_checks++;
        if ({lpc_ad_oe, reg_rd, lpc_ad_out} !== 6'b0)
            $display("FAIL async_reset: got oe=%b rd=%b ad=%h expected 0/0/0",
                     lpc_ad_oe, reg_rd, lpc_ad_out);
        else
            n_pass++;
        @(negedge lpc_clk);
        n_checks++;
        if (exp_lad.size() != 0 || exp_req.size() != 0)
            $display("FAIL async_reset_pending: got lad=%0d req=%0d expected 0/0",
                     exp_lad.size(), exp_req.size());
        else
            n_pass++;
        @(negedge lpc_clk);
        lpc_rst = 1'b1;
        @(negedge lpc_clk);
        lpc_cycle("wr_after_reset", 1'b1, 16'h03FF, 8'h3C, 8'h00, 1);
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_miss();
        test_timeout();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
